pc_fetch_unit: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline, sitting directly upstream of the IF/ID register. It holds the PC and selects the next PC from sequential, branch or jump sources. It drives the instruction-ROM address, presents PC+4 and the fetched word to IF/ID, and generates the IF/ID flush and stall controls. It also implements a RUN/HALT state machine for syscall halt, plus cycle and instruction counters for the FPGA display.

---
 rtl/pc_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_unit
//  Description : MIPS instruction-fetch stage. Holds the PC and selects the
//                next PC from jump, branch, stall or sequential sources. It
//                drives the ROM address and the IF/ID flush and pause
//                controls, and runs a RUN/HALT machine for syscall halt.
//                Cycle and instruction counters are kept for the board
//                display.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 10,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,            // synchronous, active-low
    input  logic              pause,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic              jump,
    input  logic [31:0]       jump_target,
    input  logic              halt_req,
    input  logic              go,
    input  logic [31:0]       inst_in,
    output logic [ADDR_W-1:0] inst_addr,
    output logic [31:0]       pc_out,
    output logic [31:0]       pc_plus4,
    output logic [31:0]       inst_out,
    output logic              flush_out,
    output logic              pause_out,
    output logic              halted,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  inst_cnt
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [31:0]      c_PC_STEP = 32'd4;
    localparam logic [31:0]      c_NOP     = 32'h0000_0000;

    state_t             state_q;
    logic               halted_q;
    logic [31:0]        pc_q, pc_d;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]   inst_cnt_q, inst_cnt_d;

    logic               in_run;
    logic               redirect;
    logic [31:0]        seq_pc;
    logic [31:0]        jump_pc;
    logic [31:0]        branch_pc;

    // The low two target bits are dropped silently; a misaligned target is
    // simply rounded down to the enclosing word.
    logic               target_lsb_unused;
    assign target_lsb_unused = ^{jump_target[1:0], branch_target[1:0]};

    assign in_run    = (state_q == RUN);
    assign redirect  = jump | branch_taken;
    assign seq_pc    = pc_q + c_PC_STEP;              // wraps modulo 2^32
    assign jump_pc   = {jump_target[31:2], 2'b00};
    assign branch_pc = {branch_target[31:2], 2'b00};

    // Next PC and counter values: redirects beat stall, stall beats advance;
    // everything holds while halted.
    always_comb begin
        pc_d        = pc_q;
        cycle_cnt_d = cycle_cnt_q;
        inst_cnt_d  = inst_cnt_q;
        if (in_run) begin
            cycle_cnt_d = cycle_cnt_q + c_CNT_ONE;
            if (jump) begin
                pc_d = jump_pc;
            end else if (branch_taken) begin
                pc_d = branch_pc;
            end else if (!pause) begin
                pc_d = seq_pc;
            end
            if (redirect || !pause) begin
                inst_cnt_d = inst_cnt_q + c_CNT_ONE;
            end
        end
    end

    // PC and performance-counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q        <= RESET_PC;
            cycle_cnt_q <= '0;
            inst_cnt_q  <= '0;
        end else begin
            pc_q        <= pc_d;
            cycle_cnt_q <= cycle_cnt_d;
            inst_cnt_q  <= inst_cnt_d;
        end
    end

    // RUN/HALT machine with a registered halted flag; halt_req only matters
    // in RUN and go only matters in HALT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (halt_req) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end
                end
                HALT: begin
                    if (go) begin
                        state_q  <= RUN;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    // A redirect squashes the wrong-path fetch, so it also cancels any stall
    // of IF/ID; in HALT IF/ID is held so the nop stays put.
    assign flush_out = redirect & in_run;
    assign pause_out = in_run ? (pause & ~flush_out) : 1'b1;

    assign inst_addr = pc_q[ADDR_W+1:2];
    assign pc_out    = pc_q;
    assign pc_plus4  = seq_pc;
    assign inst_out  = in_run ? inst_in : c_NOP;
    assign halted    = halted_q;
    assign cycle_cnt = cycle_cnt_q;
    assign inst_cnt  = inst_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch_unit
//  Description : Directed bench for pc_fetch_unit. A stimulus process queues
//                the expected output snapshot for every cycle; a monitor
//                pops and compares it on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 32;

    logic              clk;
    logic              rst;
    logic              pause;
    logic              branch_taken;
    logic [31:0]       branch_target;
    logic              jump;
    logic [31:0]       jump_target;
    logic              halt_req;
    logic              go;
    logic [31:0]       inst_in;
    logic [ADDR_W-1:0] inst_addr;
    logic [31:0]       pc_out;
    logic [31:0]       pc_plus4;
    logic [31:0]       inst_out;
    logic              flush_out;
    logic              pause_out;
    logic              halted;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  inst_cnt;

    pc_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .ADDR_W   (ADDR_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pause         (pause),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .halt_req      (halt_req),
        .go            (go),
        .inst_in       (inst_in),
        .inst_addr     (inst_addr),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .inst_out      (inst_out),
        .flush_out     (flush_out),
        .pause_out     (pause_out),
        .halted        (halted),
        .cycle_cnt     (cycle_cnt),
        .inst_cnt      (inst_cnt)
    );

    // Combinational ROM stand-in: the word tags its own address.
    assign inst_in = {16'hC0DE, 6'b000000, inst_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [9:0]  addr;
        logic [31:0] inst;
        logic        halt;
        logic        fl;
        logic        po;
        logic [31:0] cyc;
        logic [31:0] ins;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 0;

    task automatic chk(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", name, field, act, exp);
        end
    endtask

    // Monitor: one expected snapshot per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, "pc_out",    pc_out,             e.pc);
            chk(e.name, "pc_plus4",  pc_plus4,           e.pc4);
            chk(e.name, "inst_addr", {22'd0, inst_addr}, {22'd0, e.addr});
            chk(e.name, "inst_out",  inst_out,           e.inst);
            chk(e.name, "halted",    {31'd0, halted},    {31'd0, e.halt});
            chk(e.name, "flush_out", {31'd0, flush_out}, {31'd0, e.fl});
            chk(e.name, "pause_out", {31'd0, pause_out}, {31'd0, e.po});
            chk(e.name, "cycle_cnt", cycle_cnt,          e.cyc);
            chk(e.name, "inst_cnt",  inst_cnt,           e.ins);
        end
    end

    // Apply one cycle of inputs, queue the outputs expected during that
    // cycle, then advance past the rising edge.
    task automatic step(input string name, input logic rs,
                        input logic p, input logic br, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt,
                        input logic h, input logic g,
                        input logic [31:0] e_pc, input logic e_halt,
                        input logic e_fl, input logic e_po,
                        input logic [31:0] e_cyc, input logic [31:0] e_ins);
        exp_t e;
        rst           = rs;
        pause         = p;
        branch_taken  = br;
        branch_target = bt;
        jump          = j;
        jump_target   = jt;
        halt_req      = h;
        go            = g;
        e.name = name;
        e.pc   = e_pc;
        e.pc4  = e_pc + 32'd4;
        e.addr = e_pc[11:2];
        e.inst = e_halt ? 32'h0 : {16'hC0DE, 6'b000000, e_pc[11:2]};
        e.halt = e_halt;
        e.fl   = e_fl;
        e.po   = e_po;
        e.cyc  = e_cyc;
        e.ins  = e_ins;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; pause = 1'b0; branch_taken = 1'b0; branch_target = '0;
        jump = 1'b0; jump_target = '0; halt_req = 1'b0; go = 1'b0;
        @(posedge clk);
        #1;
        //    name        rst p br bt            j  jt            h  g  pc            hl fl po cyc ins
        step("reset",     0, 0, 0, 32'h0,      0, 32'h0,      0, 0, 32'h0,      0, 0, 0, 0,  0);
        step("run0",      1, 0, 0, 32'h0,      0, 32'h0,      0, 0, 32'h0,      0, 0, 0, 0,  0);
        step("run4",      1, 0, 0, 32'h0,      0, 32'h0,      0, 0, 32'h4,      0, 0, 0, 1,  1);
        step("run8",      1, 0, 0, 32'h0,      0, 32'h0,      0, 0, 32'h8,      0, 0, 0, 2,  2);
        step("runC",      1, 0, 0, 32'h0,      0, 32'h0,      0, 0, 32'hC,      0, 0, 0, 3,  3);
        step("stall1",    1, 1, 0, 32'h0,      0, 32'h0,      0, 0, 32'h10,     0, 0, 1, 4,  4);
        step("stall2",    1, 1, 0, 32'h0,      0, 32'h0,      0, 0, 32'h10,     0, 0, 1, 5,  4);
        step("unstall",   1, 0, 0, 32'h0,      0, 32'h0,      0, 0, 32'h10,     0, 0, 0, 6,  4);
        step("run14",     1, 0, 0, 32'h0,      0, 32'h0,      0, 0, 32'h14,     0, 0, 0, 7,  5);
        step("run18",     1, 0, 0, 32'h0,      0, 32'h0,      0, 0, 32'h18,     0, 0, 0, 8,  6);
        step("run1C",     1, 0, 0, 32'h0,      0, 32'h0,      0, 0, 32'h1C,     0, 0, 0, 9,  7);
        step("prio",      1, 1, 1, 32'h80,     1, 32'h100,    0, 0, 32'h20,     0, 1, 0, 10, 8);
        step("br_misal",  1, 0, 1, 32'h43,     0, 32'h0,      0, 0, 32'h100,    0, 1, 0, 11, 9);
        step("j_misal",   1, 1, 0, 32'h0,      1, 32'h33,     0, 0, 32'h40,     0, 1, 0, 12, 10);
        step("halt_req",  1, 0, 0, 32'h0,      0, 32'h0,      1, 0, 32'h30,     0, 0, 0, 13, 11);
        for (int k = 0; k < 5; k++)
            step("halt_hold", 1, 1, 1, 32'h80,  1, 32'h200,    1, 0, 32'h34,     1, 0, 1, 14, 12);
        step("go",        1, 0, 0, 32'h0,      0, 32'h0,      0, 1, 32'h34,     1, 0, 1, 14, 12);
        step("resumed",   1, 0, 0, 32'h0,      0, 32'h0,      0, 0, 32'h34,     0, 0, 0, 14, 12);
        step("go_in_run", 1, 0, 0, 32'h0,      0, 32'h0,      0, 1, 32'h38,     0, 0, 0, 15, 13);
        step("halt_redir",1, 0, 0, 32'h0,      1, 32'h80,     1, 0, 32'h3C,     0, 1, 0, 16, 14);
        step("halt_go",   1, 0, 0, 32'h0,      0, 32'h0,      0, 1, 32'h80,     1, 0, 1, 17, 15);
        step("j_top",     1, 0, 0, 32'h0,      1, 32'hFFFF_FFFC, 0, 0, 32'h80,  0, 1, 0, 17, 15);
        step("wrap",      1, 0, 0, 32'h0,      0, 32'h0,      0, 0, 32'hFFFF_FFFC, 0, 0, 0, 18, 16);
        step("wrapped",   1, 0, 0, 32'h0,      0, 32'h0,      0, 0, 32'h0,      0, 0, 0, 19, 17);
        step("halt_pause",1, 1, 0, 32'h0,      0, 32'h0,      1, 0, 32'h4,      0, 0, 1, 20, 18);
        step("rst_halt",  0, 0, 0, 32'h0,      0, 32'h0,      0, 0, 32'h4,      1, 0, 1, 21, 18);
        step("post_rst",  1, 0, 0, 32'h0,      0, 32'h0,      0, 0, 32'h0,      0, 0, 0, 0,  0);
        step("post_rst4", 1, 0, 0, 32'h0,      0, 32'h0,      0, 0, 32'h4,      0, 0, 0, 1,  1);
        stim_done = 1;
    end

    // Drain the scoreboard with a bounded wait, then report.
    initial begin
        int budget;
        budget = 0;
        while (!stim_done && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        if (!stim_done) begin
            errors++;
            $display("FAIL timeout: stimulus not finished after %0d cycles", budget);
        end
        budget = 0;
        while (sb.size() > 0 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d snapshots left, expected 0", sb.size());
        end
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
